alu_sw_sequencer: RTL

ALU_SW_SEQUENCER -- requirements
Module: alu_sw_sequencer

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/btn_debounce.sv | 85 ++++++++
 rtl/alu_sw_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the switch-driven ALU operand sequencer:
//   - the eight supported ALU opcode encodings
//   - the sequencer FSM state encodings (also shown on the board LEDs)
//   - the default opcode width
//   - is_known_op(): membership test used by the optional opcode validation
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int N_OP_DEFAULT = 6;
    localparam int OP_W         = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_DONE = 2'b11
    } seq_state_t;

    // True when the code is one of the opcodes the ALU implements.
    function automatic logic is_known_op(input logic [OP_W-1:0] op);
        logic known;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: known = 1'b1;
            default:                        known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Turns a raw asynchronous pushbutton into a single-cycle press event.
//   2-flop synchronizer -> stability counter -> rising-edge pulse.
// The debounced level only follows the synchronized level after it has
// differed for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts
// the count. Only presses (0->1) generate a pulse.
//
// Parameters
//   DEBOUNCE_CYCLES : cycles a new level must be stable to be accepted (>= 1)
// Ports
//   i_clock   : clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   i_btn     : raw button level, active-high
//   o_pulse   : registered one-cycle press event
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             pulse_r;

    logic             differ_s;
    logic             expire_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             level_next_s;
    logic             rise_s;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= i_btn;
            sync2_r <= sync1_r;
        end
    end

    // Stability counting: the level flips on the cycle the count expires.
    always_comb begin
        differ_s     = sync2_r ^ level_r;
        expire_s     = differ_s && (cnt_r == CNT_LAST);
        cnt_next_s   = cnt_r;
        level_next_s = level_r;
        rise_s       = 1'b0;
        if (!differ_s) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (expire_s) begin
            cnt_next_s   = {CNT_W{1'b0}};
            level_next_s = sync2_r;
            rise_s       = sync2_r;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Counter, debounced level and registered press pulse.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_next_s;
            level_r <= level_next_s;
            pulse_r <= rise_s;
        end
    end

    assign o_pulse = pulse_r;

endmodule

// File: rtl/alu_sw_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sw_sequencer
// Lets a user enter ALU operand A, operand B and the opcode one after another
// on a single bank of board switches, stepping with a "next" pushbutton.
// Sequence: S_A -> S_B -> S_OP -> S_DONE -> S_A ... Each press latches the
// switches into the field of the current state; completing the opcode gives a
// one-cycle o_valid. Latched fields hold until individually overwritten.
//
// Optional feature (macro ALU_SEQ_OP_CHECK_EN): opcodes outside the supported
// set are rejected in S_OP (field unchanged, state kept, o_op_error pulse).
// Without the macro every opcode is accepted and o_op_error is constant 0.
//
// Parameters
//   N_SW, N_OPERANDS, N_OP, DEBOUNCE_CYCLES
// Ports
//   i_clock, i_reset_n (async active-low), i_sw, i_button_next (raw)
//   o_alu_A, o_alu_B, o_alu_Op : latched fields
//   o_valid    : one-cycle pulse after the opcode is latched
//   o_state    : FSM state for LED display
//   o_op_error : one-cycle pulse on a rejected opcode
// -----------------------------------------------------------------------------
module alu_sw_sequencer
    import alu_pkg::*;
#(
    parameter int N_SW            = 16,
    parameter int N_OPERANDS      = 8,
    parameter int N_OP            = N_OP_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [N_SW-1:0]       i_sw,
    input  logic                  i_button_next,
    output logic [N_OPERANDS-1:0] o_alu_A,
    output logic [N_OPERANDS-1:0] o_alu_B,
    output logic [N_OP-1:0]       o_alu_Op,
    output logic                  o_valid,
    output logic [1:0]            o_state,
    output logic                  o_op_error
);

    seq_state_t            state_r;
    seq_state_t            state_next_s;
    logic                  evt_s;
    logic                  op_ok_s;

    logic [N_OPERANDS-1:0] a_r;
    logic [N_OPERANDS-1:0] b_r;
    logic [N_OP-1:0]       op_r;
    logic                  valid_r;

    logic [N_OPERANDS-1:0] a_next_s;
    logic [N_OPERANDS-1:0] b_next_s;
    logic [N_OP-1:0]       op_next_s;
    logic                  valid_next_s;

    // Only part of the switch bank feeds the fields; fold the rest here.
    logic                  unused_sw_s;
    assign unused_sw_s = ^i_sw;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_btn     (i_button_next),
        .o_pulse   (evt_s)
    );

`ifdef ALU_SEQ_OP_CHECK_EN
    assign op_ok_s = is_known_op(i_sw[OP_W-1:0]);
`else
    assign op_ok_s = 1'b1;
`endif

    // FSM state register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= S_A;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: advance only on a press; a rejected opcode stays put.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_A: begin
                if (evt_s) state_next_s = S_B;
                else       state_next_s = state_r;
            end
            S_B: begin
                if (evt_s) state_next_s = S_OP;
                else       state_next_s = state_r;
            end
            S_OP: begin
                if (evt_s && op_ok_s) state_next_s = S_DONE;
                else                  state_next_s = state_r;
            end
            S_DONE: begin
                if (evt_s) state_next_s = S_A;
                else       state_next_s = state_r;
            end
            default: state_next_s = S_A;
        endcase
    end

    // FSM outputs: switches are captured only on the press cycle.
    always_comb begin
        a_next_s     = a_r;
        b_next_s     = b_r;
        op_next_s    = op_r;
        valid_next_s = 1'b0;
        case (state_r)
            S_A: begin
                if (evt_s) a_next_s = i_sw[N_OPERANDS-1:0];
                else       a_next_s = a_r;
            end
            S_B: begin
                if (evt_s) b_next_s = i_sw[N_OPERANDS-1:0];
                else       b_next_s = b_r;
            end
            S_OP: begin
                if (evt_s && op_ok_s) begin
                    op_next_s    = i_sw[N_OP-1:0];
                    valid_next_s = 1'b1;
                end else begin
                    op_next_s    = op_r;
                    valid_next_s = 1'b0;
                end
            end
            S_DONE:  valid_next_s = 1'b0;
            default: valid_next_s = 1'b0;
        endcase
    end

    // Latched fields and the valid pulse.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            a_r     <= {N_OPERANDS{1'b0}};
            b_r     <= {N_OPERANDS{1'b0}};
            op_r    <= {N_OP{1'b0}};
            valid_r <= 1'b0;
        end else begin
            a_r     <= a_next_s;
            b_r     <= b_next_s;
            op_r    <= op_next_s;
            valid_r <= valid_next_s;
        end
    end

`ifdef ALU_SEQ_OP_CHECK_EN
    logic op_err_r;

    // Rejected-opcode pulse, one cycle after the offending press.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            op_err_r <= 1'b0;
        end else begin
            op_err_r <= (state_r == S_OP) && evt_s && !op_ok_s;
        end
    end

    assign o_op_error = op_err_r;
`else
    assign o_op_error = 1'b0;
`endif

    assign o_alu_A  = a_r;
    assign o_alu_B  = b_r;
    assign o_alu_Op = op_r;
    assign o_valid  = valid_r;
    assign o_state  = state_r;

endmodule
